lut_logic_unit: RTL and testbench
=================================

# lut_logic_unit

Parametrised, sequential successor to the single-gate mux exercises. Each bit of a WIDTH-bit two-operand logic function is evaluated by a 4:1 mux "LUT" built from three instances of the 2:1 `mux` primitive. The mux data inputs are the bits of a 4-bit truth table, so any of the 16 two-input functions (AND, OR, XOR, NAND, ...) is selectable at run time. Operands are processed bit-serially, LANES bits per cycle, under a small FSM with valid/ready handshakes on both sides. The block sits in the combinational-logic exercise track as the first block that mixes mux-built logic with control sequencing.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- LANES, 2, number of LUT instances and bits evaluated per cycle; WIDTH % LANES must be 0, otherwise elaboration fails.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- func  input  4  truth table for the operation. Result bit = func[{a_i, b_i}], i.e. index = 2·a_i + b_i.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  the source presents func/a/b.
- in_ready  output  1  the block can accept an operation.
- out_data  output  WIDTH  result register.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  the sink accepts out_data.
- busy  output  1  high in RUN or DONE.

## Operation
- N = WIDTH / LANES slices. The slice counter is max(1, $clog2(N)) bits wide.
- Each lane is a 4:1 LUT built from three `mux` instances:
  - first level: sel = b_i, choosing between func[0]/func[1] and between func[2]/func[3];
  - second level: sel = a_i.
  - No behavioural `&`, `|` or `^` is used for the function itself.
- Example encodings: 4'b1000 = AND, 4'b1110 = OR, 4'b0110 = XOR, 4'b0111 = NAND, 4'b1100 = pass A, 4'b1010 = pass B.
- States and transitions:
  - IDLE: in_ready = 1. If in_valid is high, capture func/a/b into internal registers, clear the result register, set the counter to 0, and go to RUN.
  - RUN: the lanes evaluate bits [cnt·LANES +: LANES] of the captured operands and write them into the same bit positions of the result register. The counter increments. When cnt == N−1, the write happens and the FSM goes to DONE instead of incrementing.
  - DONE: out_valid = 1 and out_data is stable. If out_ready is high, go to IDLE.
- in_ready is 0 outside IDLE. in_valid in RUN or DONE is ignored and does not queue.
- Inputs change freely after acceptance; only the captured copies are used.
- Output register sequence: out_data is 0 from acceptance until the first slice write, accumulates slice by slice during RUN, then holds the final value through DONE and IDLE until the next acceptance.

## Timing
- Reset, asynchronous on rst rising:
  - state = IDLE, counter = 0, result = 0, captured operands = 0;
  - out_valid = 0, busy = 0, in_ready = 1.
  - Handshakes are ignored while rst is high.
- Reset mid-operation (RUN or DONE): the operation is discarded and no out_valid is produced. After rst deasserts, the first in_valid is accepted normally.
- Latency: acceptance on clock edge E0; slices are written on E1..EN; out_valid rises immediately after EN.
- Minimum cycles per operation: N + 2 (accept, N RUN cycles, one DONE cycle with out_ready = 1).
- LANES == WIDTH (N = 1): RUN lasts exactly one cycle.
- Backpressure: out_valid stays high and out_data stays constant for as long as out_ready is low, with no upper bound.
- out_ready with out_valid low has no effect.
- in_valid and out_ready both high in DONE: the output transfer completes, in_valid is ignored, and in_ready rises in the next cycle (IDLE).

## Test plan
- Default parameters, func = 4'b1000, a = 8'hA5, b = 8'h3C, out_ready = 1: out_data = 8'h24 with out_valid high exactly 4 cycles after the accept edge; busy is high from E1 through the DONE cycle.
- Same operands with func = 4'b0110 (XOR) -> 8'h99; 4'b1110 (OR) -> 8'hBD; 4'b0111 (NAND) -> 8'hDB. All 16 func codes are run against a bitwise reference model with random operands.
- Backpressure: out_ready is held low for 5 cycles after out_valid rises. out_valid stays 1 and out_data stays constant for all 5 cycles, in_ready stays 0, and the FSM returns to IDLE one edge after out_ready rises.
- in_valid pulsed during RUN with different operands: no capture, the result matches the first operation, and the second request is accepted only after the return to IDLE.
- rst asserted for 1 cycle in the middle of RUN, between edges: the outputs immediately show out_valid = 0, busy = 0, in_ready = 1. No spurious out_valid follows, and a subsequent AND of 8'hFF & 8'h0F yields 8'h0F.
- Parameter sweep, WIDTH = 8 with LANES = 1 / 4 / 8: latency is 8 / 2 / 1 cycles with identical results. An illegal combination (WIDTH = 8, LANES = 3) fails elaboration.

Source files
------------

// File: rtl/lut_logic_unit.sv
// Bit-serial two-operand logic unit: each lane is a 4:1 LUT built from three
// 2:1 mux primitives, indexed by {a_i, b_i} into a run-time truth table.

module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module lut_logic_unit #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds
  // out_data constant until out_ready is seen.

  localparam int N  = WIDTH / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
      $error("lut_logic_unit: WIDTH must be >= 1 and a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [LANES-1:0] a_slice, b_slice, lo, hi, lane_y;

  assign a_slice = a_q[int'(cnt_q)*LANES +: LANES];
  assign b_slice = b_q[int'(cnt_q)*LANES +: LANES];

  // b selects within each half of the truth table, a selects the half.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      mux u_lo  (.d0(func_q[0]), .d1(func_q[1]), .sel(b_slice[i]), .y(lo[i]));
      mux u_hi  (.d0(func_q[2]), .d1(func_q[3]), .sel(b_slice[i]), .y(hi[i]));
      mux u_out (.d0(lo[i]),     .d1(hi[i]),     .sel(a_slice[i]), .y(lane_y[i]));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          func_d  = func;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[int'(cnt_q)*LANES +: LANES] = lane_y;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_lut_logic_unit.sv
// Directed bench for lut_logic_unit: default configuration plus a LANES sweep.

module tb_lut_logic_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] func;
  logic [7:0] a, b;
  logic       in_valid, out_ready, sw_valid;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;

  logic       l1_rdy, l1_val, l1_busy, l4_rdy, l4_val, l4_busy, l8_rdy, l8_val, l8_busy;
  logic [7:0] l1_data, l4_data, l8_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lut_logic_unit #(.WIDTH(8), .LANES(2)) dut (
    .clk(clk), .rst(rst), .func(func), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  lut_logic_unit #(.WIDTH(8), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .func(func), .a(a), .b(b), .in_valid(sw_valid),
    .in_ready(l1_rdy), .out_data(l1_data), .out_valid(l1_val),
    .out_ready(1'b1), .busy(l1_busy));

  lut_logic_unit #(.WIDTH(8), .LANES(4)) dut_l4 (
    .clk(clk), .rst(rst), .func(func), .a(a), .b(b), .in_valid(sw_valid),
    .in_ready(l4_rdy), .out_data(l4_data), .out_valid(l4_val),
    .out_ready(1'b1), .busy(l4_busy));

  lut_logic_unit #(.WIDTH(8), .LANES(8)) dut_l8 (
    .clk(clk), .rst(rst), .func(func), .a(a), .b(b), .in_valid(sw_valid),
    .in_ready(l8_rdy), .out_data(l8_data), .out_valid(l8_val),
    .out_ready(1'b1), .busy(l8_busy));

  function automatic logic [7:0] ref_logic(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = f[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("accept_wait", guard < 50, 1);
    func = f; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); func = 4'($urandom_range(0, 15));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
  endtask

  initial begin
    int lat, lat1, lat4, lat8;
    logic [7:0] held, d1, d4, d8, ra, rb;
    logic [3:0] fcode;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
    func = 4'h0; a = 8'h00; b = 8'h00;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // AND: latency, busy, then return to IDLE with held result
    run_op(4'b1000, 8'hA5, 8'h3C, lat);
    check("and_lat", lat, 4);
    check("and_data", out_data, 8'h24);
    check("and_busy", busy, 1);
    check("and_in_ready", in_ready, 0);
    @(negedge clk);
    check("and_idle_ready", in_ready, 1);
    check("and_idle_valid", out_valid, 0);
    check("and_idle_hold", out_data, 8'h24);

    run_op(4'b0110, 8'hA5, 8'h3C, lat); check("xor_data", out_data, 8'h99); @(negedge clk);
    run_op(4'b1110, 8'hA5, 8'h3C, lat); check("or_data", out_data, 8'hBD); @(negedge clk);
    run_op(4'b0111, 8'hA5, 8'h3C, lat); check("nand_data", out_data, 8'hDB); @(negedge clk);
    run_op(4'b1100, 8'hA5, 8'h3C, lat); check("passa_data", out_data, 8'hA5); @(negedge clk);
    run_op(4'b1010, 8'hA5, 8'h3C, lat); check("passb_data", out_data, 8'h3C); @(negedge clk);

    for (int f = 0; f < 16; f++) begin
      fcode = 4'(f);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(fcode, ra, rb, lat);
      check($sformatf("func_%0d", f), out_data, ref_logic(fcode, ra, rb));
      @(negedge clk);
    end

    // Backpressure
    out_ready = 1'b0;
    run_op(4'b0110, 8'hF0, 8'h3C, lat);
    held = out_data;
    check("bp_data", held, 8'hCC);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_hold", out_data, 8'hCC);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", in_ready, 1);

    // in_valid held high through RUN and DONE with other operands
    func = 4'b1110; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    func = 4'b1000; a = 8'hFF; b = 8'hFF;
    lat = 0;
    do begin
      check("hold_no_ready", in_ready, 0);
      @(negedge clk); lat++;
    end while (!out_valid && lat < 50);
    check("hold_lat", lat, 4);
    check("hold_data", out_data, 8'h33);
    @(negedge clk);
    check("hold_idle_ready", in_ready, 1);
    check("hold_idle_valid", out_valid, 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("second_busy", busy, 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
    check("second_lat", lat, 4);
    check("second_data", out_data, 8'hFF);
    @(negedge clk);

    // Reset mid-RUN between edges
    func = 4'b1110; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_spurious", seen, 0);
    run_op(4'b1000, 8'hFF, 8'h0F, lat);
    check("mrst_after_data", out_data, 8'h0F);
    check("mrst_after_lat", lat, 4);
    @(negedge clk);

    // LANES sweep on the same operation
    func = 4'b0110; a = 8'hA5; b = 8'h3C; sw_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sw_valid = 1'b0;
    lat1 = 0; lat4 = 0; lat8 = 0; d1 = 8'h00; d4 = 8'h00; d8 = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (l1_val && lat1 == 0) begin lat1 = c; d1 = l1_data; end
      if (l4_val && lat4 == 0) begin lat4 = c; d4 = l4_data; end
      if (l8_val && lat8 == 0) begin lat8 = c; d8 = l8_data; end
    end
    check("sweep_l1_lat", lat1, 8);
    check("sweep_l4_lat", lat4, 2);
    check("sweep_l8_lat", lat8, 1);
    check("sweep_l1_data", d1, 8'h99);
    check("sweep_l4_data", d4, 8'h99);
    check("sweep_l8_data", d8, 8'h99);
    check("sweep_main_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
